// File: rtl/mem_stage_lsu.sv
// Memory pipeline stage: byte/half/word loads and stores on a word-organised
// data memory, with configurable latency, valid/ready toward execute and flush.
module mem_stage_lsu #(
    parameter int DEPTH   = 1024,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_m,
    output logic        ready_m,
    input  logic        flush_m,
    input  logic        RegWriteM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    output logic        valid_w,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic        misalign_w
);
    localparam int         AW       = $clog2(DEPTH);
    localparam bit         MULTI    = (MEM_LAT > 1);
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        result_src;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
        logic [31:0] addr;
        logic        misalign;
    } req_t;

    state_t      state, state_n;
    logic [3:0]  cnt;
    req_t        in_req, lat_req, out_req;
    logic        accept, latch, fast, complete, out_en;
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata;
    logic [31:0] wdata_lane;
    logic [3:0]  be;
    logic        out_load;

    function automatic logic is_misaligned(input logic mem_op, input logic [2:0] f3,
                                           input logic [1:0] off);
        if (!mem_op) return 1'b0;
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    always_comb begin
        in_req.reg_write  = RegWriteM;
        in_req.mem_read   = MemReadM;
        in_req.mem_write  = MemWriteM;
        in_req.result_src = ResultSrcM;
        in_req.funct3     = Funct3M;
        in_req.rd         = RD_M;
        in_req.pc_plus4   = PCPlus4M;
        in_req.addr       = ALU_ResultM;
        in_req.misalign   = is_misaligned(MemReadM | MemWriteM, Funct3M, ALU_ResultM[1:0]);
    end

    // Non-memory ops always take the single-cycle path, even when MEM_LAT>1.
    always_comb begin
        state_n  = state;
        ready_m  = (state == IDLE);
        accept   = valid_m & ready_m & ~flush_m;
        latch    = 1'b0;
        fast     = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (MULTI && (MemReadM | MemWriteM)) begin
                        latch   = 1'b1;
                        state_n = BUSY;
                    end else begin
                        fast = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (flush_m) begin
                    state_n = IDLE;
                end else if (cnt == 4'd0) begin
                    complete = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        out_en   = fast | complete;
        out_req  = complete ? lat_req : in_req;
        out_load = out_req.mem_read & ~out_req.mem_write;
    end

    // Load data is read at completion, so it observes every earlier store.
    assign rdata = mem[out_req.addr[AW+1:2]];

    always_comb begin
        be         = 4'b0001 << ALU_ResultM[1:0];
        wdata_lane = {4{WriteDataM[7:0]}};
        case (Funct3M[1:0])
            2'b00: ;
            2'b01: begin
                be         = ALU_ResultM[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{WriteDataM[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = WriteDataM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && accept && MemWriteM && !in_req.misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[ALU_ResultM[AW+1:2]][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            lat_req     <= '0;
            valid_w     <= 1'b0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RD_W        <= 5'd0;
            PCPlus4W    <= 32'd0;
            ALU_ResultW <= 32'd0;
            ReadDataW   <= 32'd0;
            misalign_w  <= 1'b0;
        end else begin
            state     <= state_n;
            valid_w   <= out_en;
            RegWriteW <= out_en & out_req.reg_write & ~out_req.misalign;
            if (latch) begin
                lat_req <= in_req;
                cnt     <= CNT_INIT;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (out_en) begin
                ResultSrcW  <= out_req.result_src;
                RD_W        <= out_req.rd;
                PCPlus4W    <= out_req.pc_plus4;
                ALU_ResultW <= out_req.addr;
                ReadDataW   <= (out_load && !out_req.misalign)
                               ? extend(rdata, out_req.funct3, out_req.addr[1:0]) : 32'd0;
                misalign_w  <= out_req.misalign;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: one instance at MEM_LAT=1, one at MEM_LAT=3, checked by
// a vector table, hand sequences, and randomized ops against a byte-array model.
module tb_mem_stage_lsu;
    localparam int          DEPTH = 64;
    localparam int unsigned MEMB  = DEPTH * 4;

    typedef struct {
        logic        valid, flush, rw, mr, mw, rs;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] pc, addr, wdata;
    } op_t;

    typedef struct {
        op_t         op;
        logic        ev, erw, emis, chk;
        logic [4:0]  erd;
        logic [31:0] ealu, erdata;
    } vec_t;

    logic        clk, rst;
    op_t         op [2];
    logic        rdy [2], vw [2], rww [2], rsw [2], misw [2];
    logic [4:0]  rdw [2];
    logic [31:0] pcw [2], aluw [2], rdd [2];

    int checks = 0;
    int errors = 0;

    mem_stage_lsu #(.DEPTH(DEPTH), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .valid_m(op[0].valid), .ready_m(rdy[0]), .flush_m(op[0].flush),
        .RegWriteM(op[0].rw), .MemReadM(op[0].mr), .MemWriteM(op[0].mw), .ResultSrcM(op[0].rs),
        .Funct3M(op[0].f3), .RD_M(op[0].rd), .PCPlus4M(op[0].pc), .ALU_ResultM(op[0].addr),
        .WriteDataM(op[0].wdata), .valid_w(vw[0]), .RegWriteW(rww[0]), .ResultSrcW(rsw[0]),
        .RD_W(rdw[0]), .PCPlus4W(pcw[0]), .ALU_ResultW(aluw[0]), .ReadDataW(rdd[0]),
        .misalign_w(misw[0]));

    mem_stage_lsu #(.DEPTH(DEPTH), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .valid_m(op[1].valid), .ready_m(rdy[1]), .flush_m(op[1].flush),
        .RegWriteM(op[1].rw), .MemReadM(op[1].mr), .MemWriteM(op[1].mw), .ResultSrcM(op[1].rs),
        .Funct3M(op[1].f3), .RD_M(op[1].rd), .PCPlus4M(op[1].pc), .ALU_ResultM(op[1].addr),
        .WriteDataM(op[1].wdata), .valid_w(vw[1]), .RegWriteW(rww[1]), .ResultSrcW(rsw[1]),
        .RD_W(rdw[1]), .PCPlus4W(pcw[1]), .ALU_ResultW(aluw[1]), .ReadDataW(rdd[1]),
        .misalign_w(misw[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic op_t idle_op();
        op_t o;
        o.valid = 0; o.flush = 0; o.rw = 0; o.mr = 0; o.mw = 0; o.rs = 0;
        o.f3 = 0; o.rd = 0; o.pc = 0; o.addr = 0; o.wdata = 0;
        return o;
    endfunction

    function automatic op_t mk(input logic mr, input logic mw, input logic rw, input logic [2:0] f3,
                               input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] wdata);
        op_t o;
        o = idle_op();
        o.valid = 1; o.mr = mr; o.mw = mw; o.rw = rw; o.rs = mr; o.f3 = f3;
        o.rd = rd; o.pc = addr + 32'd4; o.addr = addr; o.wdata = wdata;
        return o;
    endfunction

    function automatic vec_t mkv(input op_t o, input logic ev, input logic erw, input logic emis,
                                 input logic [4:0] erd, input logic [31:0] ealu, input logic chk_rd,
                                 input logic [31:0] erdata);
        vec_t v;
        v.op = o; v.ev = ev; v.erw = erw; v.emis = emis; v.erd = erd;
        v.ealu = ealu; v.chk = chk_rd; v.erdata = erdata;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0]  rmem [2][MEMB];
    int          busy_left [2];
    op_t         pend [2];
    logic        e_v [2], e_rw [2], e_rs [2], e_mis [2];
    logic [4:0]  e_rd [2];
    logic [31:0] e_pc [2], e_alu [2], e_rdata [2];
    bit          known [2];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_mis(input op_t o);
        if (!(o.mr || o.mw)) return 0;
        return (int'(o.addr[1:0]) % acc_size(o.f3)) != 0;
    endfunction

    task automatic model_store(input int k, input op_t o);
        for (int b = 0; b < acc_size(o.f3); b++)
            rmem[k][(o.addr + 32'(b)) % MEMB] = o.wdata[8*b +: 8];
    endtask

    function automatic logic [31:0] model_load(input int k, input op_t o);
        int          sz;
        logic [31:0] v;
        sz = acc_size(o.f3);
        v  = 0;
        for (int b = 0; b < sz; b++)
            v = v | (32'(rmem[k][(o.addr + 32'(b)) % MEMB]) << (8 * b));
        if (sz < 4 && !o.f3[2] && v[8*sz-1])
            v = v | ~((32'd1 << (8 * sz)) - 32'd1);
        return v;
    endfunction

    task automatic model_complete(input int k, input op_t o);
        bit m;
        m = is_mis(o);
        e_v[k] = 1; e_rw[k] = o.rw && !m; e_rs[k] = o.rs; e_rd[k] = o.rd;
        e_pc[k] = o.pc; e_alu[k] = o.addr; e_mis[k] = m;
        if (o.mr && !o.mw) begin
            known[k]   = 1;
            e_rdata[k] = m ? 32'd0 : model_load(k, o);
        end else begin
            known[k] = 0;
        end
    endtask

    task automatic model_reset(input int k);
        busy_left[k] = 0; e_v[k] = 0; e_rw[k] = 0; e_rs[k] = 0; e_mis[k] = 0;
        e_rd[k] = 0; e_pc[k] = 0; e_alu[k] = 0; e_rdata[k] = 0; known[k] = 1;
    endtask

    task automatic model_step(input int k, input op_t o);
        e_v[k] = 0; e_rw[k] = 0;
        if (busy_left[k] > 0) begin
            if (o.flush) busy_left[k] = 0;
            else if (busy_left[k] == 1) begin
                busy_left[k] = 0;
                model_complete(k, pend[k]);
            end else busy_left[k]--;
        end else if (o.valid && !o.flush) begin
            if (o.mw && !is_mis(o)) model_store(k, o);
            if ((o.mr || o.mw) && lat(k) > 1) begin
                busy_left[k] = lat(k) - 1;
                pend[k]      = o;
            end else model_complete(k, o);
        end
    endtask

    task automatic cmp_all(input int k, input string tag);
        chk($sformatf("%s ready", tag), 32'(rdy[k]), 32'(busy_left[k] == 0));
        chk($sformatf("%s valid_w", tag), 32'(vw[k]), 32'(e_v[k]));
        chk($sformatf("%s RegWriteW", tag), 32'(rww[k]), 32'(e_rw[k]));
        chk($sformatf("%s ResultSrcW", tag), 32'(rsw[k]), 32'(e_rs[k]));
        chk($sformatf("%s RD_W", tag), 32'(rdw[k]), 32'(e_rd[k]));
        chk($sformatf("%s PCPlus4W", tag), pcw[k], e_pc[k]);
        chk($sformatf("%s ALU_ResultW", tag), aluw[k], e_alu[k]);
        chk($sformatf("%s misalign_w", tag), 32'(misw[k]), 32'(e_mis[k]));
        if (known[k]) chk($sformatf("%s ReadDataW", tag), rdd[k], e_rdata[k]);
    endtask

    function automatic op_t rand_op();
        op_t o;
        int  kind;
        o = idle_op();
        o.valid = ($urandom_range(3) != 0);
        o.flush = ($urandom_range(15) == 0);
        kind = $urandom_range(9);
        o.mr = (kind <= 3) || (kind == 7);
        o.mw = (kind >= 4 && kind <= 7);
        case ($urandom_range(4))
            0: o.f3 = 3'b000;
            1: o.f3 = 3'b001;
            2: o.f3 = 3'b010;
            3: o.f3 = 3'b100;
            default: o.f3 = 3'b101;
        endcase
        o.addr = $urandom();
        if ($urandom_range(1) == 1) o.addr[1:0] = 2'b00;
        o.rd = 5'($urandom()); o.pc = $urandom(); o.wdata = $urandom();
        o.rw = o.mr || ($urandom_range(1) == 1);
        o.rs = o.mr;
        return o;
    endfunction

    task automatic reset_both();
        rst = 1; op[0] = idle_op(); op[1] = idle_op();
        step();
        rst = 0;
        model_reset(0); model_reset(1);
        cmp_all(0, "rst0");
        cmp_all(1, "rst1");
    endtask

    task automatic run_random(input int k, input int n);
        op_t o;
        int  filled;
        bit  acc;
        filled = 0;
        for (int c = 0; c < DEPTH * 3 + 16 && filled < DEPTH; c++) begin
            o = mk(0, 1, 0, 3'b010, 0, 32'(filled * 4), $urandom());
            acc = (busy_left[k] == 0);
            op[k] = o;
            @(posedge clk);
            model_step(k, o);
            @(negedge clk);
            if (acc) filled++;
            cmp_all(k, $sformatf("fill%0d", k));
        end
        chk($sformatf("fill%0d count", k), 32'(filled), 32'(DEPTH));
        for (int c = 0; c < n; c++) begin
            o = rand_op();
            op[k] = o;
            @(posedge clk);
            model_step(k, o);
            @(negedge clk);
            cmp_all(k, $sformatf("rnd%0d c%0d", k, c));
        end
        op[k] = idle_op();
    endtask

    // ---------------- test sequence ----------------
    vec_t vt [$];
    op_t  tmp;

    initial begin
        rst = 1; op[0] = idle_op(); op[1] = idle_op();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset%0d ready", k), 32'(rdy[k]), 32'd1);
            chk($sformatf("reset%0d valid_w", k), 32'(vw[k]), 32'd0);
            chk($sformatf("reset%0d RegWriteW", k), 32'(rww[k]), 32'd0);
            chk($sformatf("reset%0d RD_W", k), 32'(rdw[k]), 32'd0);
            chk($sformatf("reset%0d ALU_ResultW", k), aluw[k], 32'd0);
            chk($sformatf("reset%0d ReadDataW", k), rdd[k], 32'd0);
            chk($sformatf("reset%0d misalign_w", k), 32'(misw[k]), 32'd0);
        end

        // MEM_LAT=1 vector table: each row is one op and the result after its edge.
        vt.push_back(mkv(mk(0,1,0,3'b010,0,32'h10,32'hDEADBEEF), 1,0,0, 0,32'h10, 0,0));
        vt.push_back(mkv(mk(1,0,1,3'b010,5,32'h10,0),            1,1,0, 5,32'h10, 1,32'hDEADBEEF));
        vt.push_back(mkv(mk(0,1,0,3'b000,0,32'h13,32'h12345680), 1,0,0, 0,32'h13, 0,0));
        vt.push_back(mkv(mk(1,0,1,3'b000,6,32'h13,0),            1,1,0, 6,32'h13, 1,32'hFFFFFF80));
        vt.push_back(mkv(mk(1,0,1,3'b100,6,32'h13,0),            1,1,0, 6,32'h13, 1,32'h00000080));
        vt.push_back(mkv(mk(1,0,1,3'b001,7,32'h12,0),            1,1,0, 7,32'h12, 1,32'hFFFF80AD));
        vt.push_back(mkv(mk(1,0,1,3'b101,7,32'h12,0),            1,1,0, 7,32'h12, 1,32'h000080AD));
        vt.push_back(mkv(mk(1,0,1,3'b010,8,32'h12,0),            1,0,1, 8,32'h12, 1,32'h0));
        vt.push_back(mkv(mk(0,1,1,3'b001,0,32'h11,32'h1234),     1,0,1, 0,32'h11, 0,0));
        vt.push_back(mkv(mk(1,0,1,3'b010,9,32'h10,0),            1,1,0, 9,32'h10, 1,32'h80ADBEEF));
        vt.push_back(mkv(mk(0,0,1,3'b010,3,32'h55AA,0),          1,1,0, 3,32'h55AA, 0,0));
        tmp = mk(0,0,1,3'b010,17,32'h999,0); tmp.valid = 0;
        vt.push_back(mkv(tmp,                                    0,0,0, 3,32'h55AA, 0,0));
        vt.push_back(mkv(mk(0,1,0,3'b010,0,32'h110,32'hCAFEF00D),1,0,0, 0,32'h110, 0,0));
        vt.push_back(mkv(mk(1,0,1,3'b010,4,32'h10,0),            1,1,0, 4,32'h10, 1,32'hCAFEF00D));
        vt.push_back(mkv(mk(1,0,1,3'b000,4,32'h10,0),            1,1,0, 4,32'h10, 1,32'h0000000D));
        vt.push_back(mkv(mk(1,0,1,3'b001,4,32'h12,0),            1,1,0, 4,32'h12, 1,32'hFFFFCAFE));
        vt.push_back(mkv(mk(1,1,0,3'b010,0,32'h14,32'h11223344), 1,0,0, 0,32'h14, 0,0));
        vt.push_back(mkv(mk(1,0,1,3'b010,2,32'h14,0),            1,1,0, 2,32'h14, 1,32'h11223344));
        tmp = mk(0,1,0,3'b010,0,32'h14,32'hFFFFFFFF); tmp.flush = 1;
        vt.push_back(mkv(tmp,                                    0,0,0, 2,32'h14, 0,0));
        vt.push_back(mkv(mk(1,0,1,3'b010,2,32'h14,0),            1,1,0, 2,32'h14, 1,32'h11223344));
        vt.push_back(mkv(mk(1,0,1,3'b001,1,32'h16,0),            1,1,0, 1,32'h16, 1,32'h00001122));

        for (int i = 0; i < vt.size(); i++) begin
            tmp = vt[i].op;
            tmp.pc = 32'h1000 + 32'(i * 4);
            op[0] = tmp;
            step();
            chk($sformatf("v%0d valid_w", i), 32'(vw[0]), 32'(vt[i].ev));
            chk($sformatf("v%0d RegWriteW", i), 32'(rww[0]), 32'(vt[i].erw));
            chk($sformatf("v%0d RD_W", i), 32'(rdw[0]), 32'(vt[i].erd));
            chk($sformatf("v%0d ALU_ResultW", i), aluw[0], vt[i].ealu);
            if (vt[i].ev) begin
                chk($sformatf("v%0d misalign_w", i), 32'(misw[0]), 32'(vt[i].emis));
                chk($sformatf("v%0d PCPlus4W", i), pcw[0], 32'h1000 + 32'(i * 4));
            end
            if (vt[i].chk) chk($sformatf("v%0d ReadDataW", i), rdd[0], vt[i].erdata);
        end
        op[0] = idle_op();

        // MEM_LAT=3: store, then load timing with a non-memory op waiting behind it.
        op[1] = mk(0,1,0,3'b010,0,32'h20,32'h0BADF00D);
        step(); op[1] = idle_op();
        chk("l3 st busy1 ready", 32'(rdy[1]), 0);
        step();
        chk("l3 st busy2 ready", 32'(rdy[1]), 0);
        chk("l3 st busy2 valid", 32'(vw[1]), 0);
        step();
        chk("l3 st done valid", 32'(vw[1]), 1);
        chk("l3 st done ready", 32'(rdy[1]), 1);
        op[1] = mk(1,0,1,3'b010,9,32'h20,0);
        step();
        chk("l3 ld c1 ready", 32'(rdy[1]), 0);
        chk("l3 ld c1 valid", 32'(vw[1]), 0);
        op[1] = mk(0,0,1,3'b000,10,32'h1234,0);
        step();
        chk("l3 ld c2 ready", 32'(rdy[1]), 0);
        chk("l3 ld c2 valid", 32'(vw[1]), 0);
        step();
        chk("l3 ld done valid", 32'(vw[1]), 1);
        chk("l3 ld done RD_W", 32'(rdw[1]), 9);
        chk("l3 ld done data", rdd[1], 32'h0BADF00D);
        chk("l3 ld done RegWriteW", 32'(rww[1]), 1);
        chk("l3 ld done ready", 32'(rdy[1]), 1);
        step(); op[1] = idle_op();
        chk("l3 alu valid", 32'(vw[1]), 1);
        chk("l3 alu RD_W", 32'(rdw[1]), 10);
        chk("l3 alu ALU_ResultW", aluw[1], 32'h1234);
        step();
        chk("l3 idle valid", 32'(vw[1]), 0);
        chk("l3 idle RegWriteW", 32'(rww[1]), 0);
        chk("l3 idle RD_W hold", 32'(rdw[1]), 10);

        // Flush in the first BUSY cycle of a load.
        op[1] = mk(1,0,1,3'b010,11,32'h20,0);
        step();
        op[1] = idle_op(); op[1].flush = 1;
        step(); op[1] = idle_op();
        chk("l3 flush ready", 32'(rdy[1]), 1);
        chk("l3 flush valid", 32'(vw[1]), 0);
        step();
        chk("l3 flush no pulse", 32'(vw[1]), 0);
        step();
        chk("l3 flush no pulse2", 32'(vw[1]), 0);
        chk("l3 flush RD_W hold", 32'(rdw[1]), 10);

        // Flushed store in BUSY stays committed; flush in IDLE drops a store.
        op[1] = mk(0,1,0,3'b010,0,32'h24,32'h600DCAFE);
        step();
        op[1] = idle_op(); op[1].flush = 1;
        step();
        op[1] = mk(0,1,0,3'b010,0,32'h24,32'h00000BAD); op[1].flush = 1;
        step();
        chk("l3 idle flush valid", 32'(vw[1]), 0);
        chk("l3 idle flush ready", 32'(rdy[1]), 1);
        op[1] = mk(1,0,1,3'b010,12,32'h24,0);
        step(); op[1] = idle_op(); step(); step();
        chk("l3 flushed st valid", 32'(vw[1]), 1);
        chk("l3 flushed st data", rdd[1], 32'h600DCAFE);

        // Reset during BUSY.
        op[1] = mk(1,0,1,3'b010,13,32'h24,0);
        step();
        rst = 1; op[1] = idle_op();
        step();
        rst = 0;
        chk("l3 rst ready", 32'(rdy[1]), 1);
        chk("l3 rst valid", 32'(vw[1]), 0);
        chk("l3 rst RD_W", 32'(rdw[1]), 0);
        chk("l3 rst ALU_ResultW", aluw[1], 0);
        chk("l3 rst PCPlus4W", pcw[1], 0);
        chk("l3 rst ReadDataW", rdd[1], 0);
        step();
        chk("l3 rst no pulse", 32'(vw[1]), 0);
        op[1] = mk(1,0,1,3'b010,14,32'h20,0);
        step(); op[1] = idle_op(); step(); step();
        chk("l3 post-rst data", rdd[1], 32'h0BADF00D);
        chk("l3 post-rst valid", 32'(vw[1]), 1);

        // Randomized traffic against the model on both latencies.
        reset_both();
        run_random(0, 400);
        run_random(1, 400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
